busca_instrucao: RTL and testbench

//  Instruction-fetch stage: holds the PC and fetches 32-bit words from instruction memory

---
 rtl/busca_instrucao.sv | 119 +++++++++++
 tb/tb_busca_instrucao.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/busca_instrucao.sv
// Instruction-fetch stage: owns the PC, fetches words over a req/ack handshake and
// hands each word with its PC to decode over valid/ready, honouring branch/jump redirects.
module busca_instrucao #(
    localparam int unsigned XLEN = 32,
    parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
    input  logic            clk,
    input  logic            reset,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_ack,
    input  logic [XLEN-1:0] imem_rdata,
    input  logic            redirect,
    input  logic [XLEN-1:0] redirect_pc,
    output logic [XLEN-1:0] instr_out,
    output logic [XLEN-1:0] pc_out,
    output logic            instr_valid,
    input  logic            instr_ready,
    output logic            misalign_err,
    output logic [XLEN-1:0] fetch_count
);

    localparam logic [XLEN-1:0] PC_STEP = XLEN'(4);

    typedef enum logic [0:0] {
        REQ  = 1'b0,
        HOLD = 1'b1
    } state_t;

    state_t          state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] pend_pc_q, pend_pc_d;
    logic            kill_q, kill_d;
    logic [XLEN-1:0] instr_d, pc_out_d, count_d;
    logic            req_d, valid_d, misalign_d;
    logic [XLEN-1:0] target;

    assign target    = {redirect_pc[XLEN-1:2], 2'b00};
    assign imem_addr = pc_q;

    // State and output registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= REQ;
            pc_q         <= RESET_PC;
            pend_pc_q    <= RESET_PC;
            kill_q       <= 1'b0;
            imem_req     <= 1'b1;
            instr_valid  <= 1'b0;
            instr_out    <= '0;
            pc_out       <= '0;
            misalign_err <= 1'b0;
            fetch_count  <= '0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            pend_pc_q    <= pend_pc_d;
            kill_q       <= kill_d;
            imem_req     <= req_d;
            instr_valid  <= valid_d;
            instr_out    <= instr_d;
            pc_out       <= pc_out_d;
            misalign_err <= misalign_d;
            fetch_count  <= count_d;
        end
    end

    // Next-state and next-output logic
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        pend_pc_d  = pend_pc_q;
        kill_d     = kill_q;
        instr_d    = instr_out;
        pc_out_d   = pc_out;
        count_d    = fetch_count;
        misalign_d = redirect && (redirect_pc[1:0] != 2'b00);

        case (state_q)
            REQ: begin
                if (imem_ack) begin
                    if (kill_q || redirect) begin
                        // Stale word: drop it and move the PC to the newest target.
                        kill_d = 1'b0;
                        pc_d   = redirect ? target : pend_pc_q;
                    end else begin
                        instr_d  = imem_rdata;
                        pc_out_d = pc_q;
                        state_d  = HOLD;
                    end
                end else if (redirect) begin
                    // Address must stay put until ack, so park the target.
                    kill_d    = 1'b1;
                    pend_pc_d = target;
                end
            end
            HOLD: begin
                if (redirect) begin
                    pc_d    = target;
                    state_d = REQ;
                    if (instr_ready) begin
                        count_d = fetch_count + XLEN'(1);
                    end
                end else if (instr_ready) begin
                    count_d = fetch_count + XLEN'(1);
                    pc_d    = pc_q + PC_STEP;
                    state_d = REQ;
                end
            end
            default: begin
                state_d = REQ;
            end
        endcase

        req_d   = (state_d == REQ);
        valid_d = (state_d == HOLD);
    end

endmodule

// File: tb/tb_busca_instrucao.sv
// Self-checking bench for busca_instrucao: table-driven fetch stream with a
// scoreboard of delivered words, plus hand-written redirect and reset sequences.
module tb_busca_instrucao;

    logic        clk = 1'b0;
    logic        reset;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic [31:0] instr_out;
    logic [31:0] pc_out;
    logic        instr_valid;
    logic        instr_ready;
    logic        misalign_err;
    logic [31:0] fetch_count;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    busca_instrucao #(.RESET_PC(RESET_PC)) dut (
        .clk          (clk),
        .reset        (reset),
        .imem_req     (imem_req),
        .imem_addr    (imem_addr),
        .imem_ack     (imem_ack),
        .imem_rdata   (imem_rdata),
        .redirect     (redirect),
        .redirect_pc  (redirect_pc),
        .instr_out    (instr_out),
        .pc_out       (pc_out),
        .instr_valid  (instr_valid),
        .instr_ready  (instr_ready),
        .misalign_err (misalign_err),
        .fetch_count  (fetch_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } sb_t;

    typedef struct {
        int unsigned ack_wait;
        int unsigned ready_wait;
        logic [31:0] rdata;
        logic [31:0] addr;
    } vec_t;

    sb_t         sb[$];
    vec_t        vecs[6];
    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] exp_count = 32'd0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Pop the expected word and compare it with what decode sees right now.
    task automatic sb_compare(input string name);
        sb_t e;
        if (sb.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s: got instr %h with empty scoreboard expected none", name, instr_out);
        end else begin
            e = sb.pop_front();
            check({name, " instr"}, instr_out, e.instr);
            check({name, " pc"}, pc_out, e.pc);
        end
    endtask

    // One complete fetch: wait states on the memory side, then stalls on decode side.
    task automatic fetch(input string name, input logic [31:0] addr, input logic [31:0] data,
                         input int unsigned ack_wait, input int unsigned ready_wait);
        sb_t e;
        for (int i = 0; i < int'(ack_wait); i++) begin
            check({name, " wait req"}, 32'(imem_req), 32'd1);
            check({name, " wait addr"}, imem_addr, addr);
            check({name, " wait valid"}, 32'(instr_valid), 32'd0);
            tick();
        end
        check({name, " req"}, 32'(imem_req), 32'd1);
        check({name, " addr"}, imem_addr, addr);
        imem_ack   = 1'b1;
        imem_rdata = data;
        e.pc = addr;
        e.instr = data;
        sb.push_back(e);
        tick();
        imem_ack   = 1'b0;
        imem_rdata = 32'hXXXX_XXXX;
        check({name, " valid"}, 32'(instr_valid), 32'd1);
        check({name, " req low"}, 32'(imem_req), 32'd0);
        for (int i = 0; i < int'(ready_wait); i++) begin
            tick();
            check({name, " stall valid"}, 32'(instr_valid), 32'd1);
            check({name, " stall instr"}, instr_out, data);
        end
        instr_ready = 1'b1;
        sb_compare(name);
        tick();
        instr_ready = 1'b0;
        exp_count++;
        check({name, " count"}, fetch_count, exp_count);
        check({name, " valid drop"}, 32'(instr_valid), 32'd0);
        check({name, " next addr"}, imem_addr, addr + 32'd4);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{0, 0, 32'h0050_0093, 32'h0000_0000};
        vecs[1] = '{0, 2, 32'h0010_8113, 32'h0000_0004};
        vecs[2] = '{3, 0, 32'h0020_81B3, 32'h0000_0008};
        vecs[3] = '{1, 1, 32'hFE20_8EE3, 32'h0000_000C};
        vecs[4] = '{2, 3, 32'h0080_006F, 32'h0000_0010};
        vecs[5] = '{0, 0, 32'h0000_0013, 32'h0000_0014};

        reset = 1'b1;
        imem_ack = 1'b0;
        imem_rdata = '0;
        redirect = 1'b0;
        redirect_pc = '0;
        instr_ready = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        check("rst req", 32'(imem_req), 32'd1);
        check("rst addr", imem_addr, RESET_PC);
        check("rst valid", 32'(instr_valid), 32'd0);
        check("rst count", fetch_count, 32'd0);
        check("rst instr", instr_out, 32'd0);
        check("rst pc_out", pc_out, 32'd0);
        check("rst misalign", 32'(misalign_err), 32'd0);

        foreach (vecs[i]) begin
            fetch($sformatf("vec%0d", i), vecs[i].addr, vecs[i].rdata,
                  vecs[i].ack_wait, vecs[i].ready_wait);
        end

        // Redirect in REQ before ack: old word must be discarded.
        redirect = 1'b1;
        redirect_pc = 32'h0000_0040;
        tick();
        redirect = 1'b0;
        check("kill addr held", imem_addr, 32'h0000_0018);
        check("kill req", 32'(imem_req), 32'd1);
        check("kill misalign", 32'(misalign_err), 32'd0);
        tick();
        imem_ack = 1'b1;
        imem_rdata = 32'hDEAD_BEEF;
        tick();
        imem_ack = 1'b0;
        check("kill no valid", 32'(instr_valid), 32'd0);
        check("kill new addr", imem_addr, 32'h0000_0040);
        fetch("after kill", 32'h0000_0040, 32'h1111_0013, 0, 0);

        // Two redirects before ack: the newest target wins.
        redirect = 1'b1;
        redirect_pc = 32'h0000_0080;
        tick();
        redirect_pc = 32'h0000_0200;
        tick();
        redirect = 1'b0;
        imem_ack = 1'b1;
        tick();
        imem_ack = 1'b0;
        check("newest valid", 32'(instr_valid), 32'd0);
        check("newest addr", imem_addr, 32'h0000_0200);

        // Redirect coincident with ack: data dropped, target taken at once.
        redirect = 1'b1;
        redirect_pc = 32'h0000_0300;
        imem_ack = 1'b1;
        tick();
        redirect = 1'b0;
        imem_ack = 1'b0;
        check("ackredir valid", 32'(instr_valid), 32'd0);
        check("ackredir addr", imem_addr, 32'h0000_0300);

        // Misaligned redirect in HOLD with ready low.
        imem_ack = 1'b1;
        imem_rdata = 32'h2222_0013;
        tick();
        imem_ack = 1'b0;
        check("hold valid", 32'(instr_valid), 32'd1);
        check("hold pc_out", pc_out, 32'h0000_0300);
        void'(sb.size());
        redirect = 1'b1;
        redirect_pc = 32'h0000_0102;
        tick();
        redirect = 1'b0;
        check("mis valid drop", 32'(instr_valid), 32'd0);
        check("mis pulse", 32'(misalign_err), 32'd1);
        check("mis addr", imem_addr, 32'h0000_0100);
        check("mis count", fetch_count, exp_count);
        tick();
        check("mis pulse end", 32'(misalign_err), 32'd0);

        // Redirect in HOLD with ready high: word still counts as delivered.
        fetch("pre redir", 32'h0000_0100, 32'h3333_0013, 0, 0);
        imem_ack = 1'b1;
        imem_rdata = 32'h4444_0013;
        sb.push_back('{pc: 32'h0000_0104, instr: 32'h4444_0013});
        tick();
        imem_ack = 1'b0;
        redirect = 1'b1;
        redirect_pc = 32'hFFFF_FFFC;
        instr_ready = 1'b1;
        sb_compare("redir ready");
        tick();
        redirect = 1'b0;
        instr_ready = 1'b0;
        exp_count++;
        check("redir ready count", fetch_count, exp_count);
        check("redir ready addr", imem_addr, 32'hFFFF_FFFC);
        check("redir ready valid", 32'(instr_valid), 32'd0);

        // PC wraps from the top of the address space to zero.
        fetch("wrap", 32'hFFFF_FFFC, 32'h5555_0013, 1, 0);

        // Reset while holding a word.
        imem_ack = 1'b1;
        imem_rdata = 32'h6666_0013;
        tick();
        imem_ack = 1'b0;
        check("pre rst valid", 32'(instr_valid), 32'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        sb.delete();
        exp_count = 32'd0;
        check("midrst valid", 32'(instr_valid), 32'd0);
        check("midrst addr", imem_addr, RESET_PC);
        check("midrst count", fetch_count, 32'd0);
        check("midrst req", 32'(imem_req), 32'd1);

        // Ack during reset is ignored.
        reset = 1'b1;
        imem_ack = 1'b1;
        imem_rdata = 32'h7777_0013;
        tick();
        reset = 1'b0;
        imem_ack = 1'b0;
        tick();
        check("rstack valid", 32'(instr_valid), 32'd0);
        check("rstack req", 32'(imem_req), 32'd1);
        fetch("post rst", RESET_PC, 32'h0050_0093, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
